// File: rtl/serial_pattern_generator_if.sv
// Bus bundle for serial_pattern_generator: transfer request inputs and serial output stream.
interface serial_pattern_generator_if #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap;
    logic             ready;
    logic             x;
    logic             valid;
    logic             frame_end;
    logic             done;

    modport master (
        output start, abort, pattern, repeat_cnt, gap,
        input  ready, x, valid, frame_end, done
    );

    modport slave (
        input  start, abort, pattern, repeat_cnt, gap,
        output ready, x, valid, frame_end, done
    );
endinterface

// File: rtl/serial_pattern_generator.sv
// Serialises a captured pattern MSB first, repeat_cnt+1 times with gap idle cycles between frames.
// Optional even-parity bit per frame: define SERIAL_PATTERN_GENERATOR_PARITY_EN.
module serial_pattern_generator #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input logic                        clk,
    input logic                        reset,
    serial_pattern_generator_if.slave  bus
);
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SEND = 3'd1;
`ifdef SERIAL_PATTERN_GENERATOR_PARITY_EN
    localparam logic [2:0] PAR  = 3'd2;
`endif
    localparam logic [2:0] GAP  = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;

    typedef struct packed {
        logic [PAT_W-1:0] pattern;
        logic [GAP_W-1:0] gap;
    } req_t;

    logic [2:0]       state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [CNT_W-1:0] frames_left, frames_left_d;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
    req_t             req, req_d;
    logic             exit_frame;

    always_comb begin
        state_d       = state;
        idx_d         = idx;
        frames_left_d = frames_left;
        gap_cnt_d     = gap_cnt;
        req_d         = req;
        exit_frame    = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                req_d.pattern = bus.pattern;
                req_d.gap     = bus.gap;
                frames_left_d = bus.repeat_cnt;
                idx_d         = IDX_TOP;
                state_d       = SEND;
            end
            SEND: begin
                if (bus.abort)
                    state_d = FIN;
                else if (idx == '0)
`ifdef SERIAL_PATTERN_GENERATOR_PARITY_EN
                    state_d = PAR;
`else
                    exit_frame = 1'b1;
`endif
                else
                    idx_d = idx - IDX_W'(1);
            end
`ifdef SERIAL_PATTERN_GENERATOR_PARITY_EN
            PAR: begin
                if (bus.abort) state_d = FIN;
                else           exit_frame = 1'b1;
            end
`endif
            GAP: begin
                if (bus.abort) begin
                    state_d = FIN;
                end else if (gap_cnt == GAP_W'(1)) begin
                    state_d = SEND;
                    idx_d   = IDX_TOP;
                end else begin
                    gap_cnt_d = gap_cnt - GAP_W'(1);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // frames_left counts frames still owed after the one just finished
        if (exit_frame) begin
            if (frames_left != '0) begin
                frames_left_d = frames_left - CNT_W'(1);
                if (req.gap != '0) begin
                    state_d   = GAP;
                    gap_cnt_d = req.gap;
                end else begin
                    state_d = SEND;
                    idx_d   = IDX_TOP;
                end
            end else begin
                state_d = FIN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            frames_left <= '0;
            gap_cnt     <= '0;
            req         <= '0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            frames_left <= frames_left_d;
            gap_cnt     <= gap_cnt_d;
            req         <= req_d;
        end
    end

    assign bus.ready = (state == IDLE);
    assign bus.done  = (state == FIN);
`ifdef SERIAL_PATTERN_GENERATOR_PARITY_EN
    assign bus.valid     = (state == SEND) || (state == PAR);
    assign bus.x         = (state == SEND) ? req.pattern[idx] :
                           (state == PAR)  ? ^req.pattern : 1'b0;
    assign bus.frame_end = (state == PAR);
`else
    assign bus.valid     = (state == SEND);
    assign bus.x         = (state == SEND) ? req.pattern[idx] : 1'b0;
    assign bus.frame_end = (state == SEND) && (idx == '0);
`endif
endmodule

// File: tb/tb_serial_pattern_generator.sv
// Self-checking bench for serial_pattern_generator: vector table, corner sequences, random transfers vs model.
module tb_serial_pattern_generator;
    localparam int PAT_W = 5;
    localparam int CNT_W = 4;
    localparam int GAP_W = 3;
`ifdef SERIAL_PATTERN_GENERATOR_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam logic FE_BIT0 = (P == 0);

    typedef struct packed {
        logic ready;
        logic x;
        logic valid;
        logic fe;
        logic done;
    } out_t;

    typedef struct {
        logic             rst;
        logic             st;
        logic             ab;
        logic [PAT_W-1:0] pat;
        logic [CNT_W-1:0] rc;
        logic [GAP_W-1:0] gp;
        out_t             e;
    } vec_t;

    localparam out_t IDLE_O = 5'b10000;
    localparam out_t DONE_O = 5'b00001;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    serial_pattern_generator_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

    serial_pattern_generator #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic st, input logic ab,
                         input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rc,
                         input logic [GAP_W-1:0] gp);
        reset          = rst;
        bus.start      = st;
        bus.abort      = ab;
        bus.pattern    = pat;
        bus.repeat_cnt = rc;
        bus.gap        = gp;
    endtask

    task automatic check(input string name, input out_t e);
        out_t a;
        a = {bus.ready, bus.x, bus.valid, bus.frame_end, bus.done};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got rdy/x/v/fe/done=%b%b%b%b%b required %b%b%b%b%b", name,
                     a.ready, a.x, a.valid, a.fe, a.done, e.ready, e.x, e.valid, e.fe, e.done);
        end
    endtask

    function automatic void add(input logic rst, input logic st, input logic ab,
                                input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rc,
                                input logic [GAP_W-1:0] gp, input out_t e);
        vec_t v;
        v.rst = rst; v.st = st; v.ab = ab; v.pat = pat; v.rc = rc; v.gp = gp; v.e = e;
        tbl.push_back(v);
    endfunction

    // Model: whole transfer expanded into per-cycle outputs; abort jumps to the trailing done entry.
    task automatic run_transfer(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rc,
                                input logic [GAP_W-1:0] gp, input int abort_pct,
                                output int done_cyc);
        out_t exp[$];
        int   f_cnt, i, cyc;
        logic ab;
        f_cnt = int'(rc) + 1;
        for (int f = 0; f < f_cnt; f++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                exp.push_back({1'b0, pat[b], 1'b1, (b == 0) && FE_BIT0, 1'b0});
            if (P == 1) exp.push_back({1'b0, ^pat, 1'b1, 1'b1, 1'b0});
            if (f < f_cnt - 1)
                for (int g = 0; g < int'(gp); g++) exp.push_back(5'b00000);
        end
        exp.push_back(DONE_O);

        drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), pat, rc, gp);
        step();
        cyc = 1;
        i = 0;
        forever begin
            check($sformatf("xfer pat=%b rc=%0d gap=%0d cyc%0d", pat, rc, gp, cyc), exp[i]);
            if (exp[i].done) break;
            ab = ($urandom_range(0, 99) < abort_pct);
            drive(1'b0, 1'($urandom_range(0, 1)), ab, PAT_W'($urandom),
                  CNT_W'($urandom), GAP_W'($urandom));
            step();
            cyc++;
            i = ab ? exp.size() - 1 : i + 1;
        end
        done_cyc = cyc;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        check("ready after done", IDLE_O);
    endtask

    initial begin
        int dc;
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);

        // reset overrides start/abort; abort in IDLE is ignored; single frame 10110
        add(1, 1, 1, 5'b10110, 0, 0, IDLE_O);
        add(0, 0, 1, 5'b10110, 0, 0, IDLE_O);
        add(0, 1, 0, 5'b10110, 0, 0, 5'b01100);
        add(0, 0, 0, 5'b10110, 0, 0, 5'b00100);
        add(0, 0, 0, 5'b10110, 0, 0, 5'b01100);
        add(0, 0, 0, 5'b10110, 0, 0, 5'b01100);
        add(0, 0, 0, 5'b10110, 0, 0, {3'b001, FE_BIT0, 1'b0});
`ifdef SERIAL_PATTERN_GENERATOR_PARITY_EN
        add(0, 0, 0, 5'b10110, 0, 0, 5'b01110);
`endif
        add(0, 0, 0, 5'b10110, 0, 0, DONE_O);
        add(0, 0, 0, 5'b10110, 0, 0, IDLE_O);
        // two back-to-back frames; start and abort together in IDLE -> start wins
        add(0, 1, 1, 5'b10110, 1, 0, 5'b01100);
        add(0, 0, 0, 5'b10110, 1, 0, 5'b00100);
        add(0, 0, 0, 5'b10110, 1, 0, 5'b01100);
        add(0, 0, 0, 5'b10110, 1, 0, 5'b01100);
        add(0, 0, 0, 5'b10110, 1, 0, {3'b001, FE_BIT0, 1'b0});
`ifdef SERIAL_PATTERN_GENERATOR_PARITY_EN
        add(0, 0, 0, 5'b10110, 1, 0, 5'b01110);
`endif
        add(0, 0, 0, 5'b10110, 1, 0, 5'b01100);
        add(0, 0, 0, 5'b10110, 1, 0, 5'b00100);
        add(0, 0, 0, 5'b10110, 1, 0, 5'b01100);
        add(0, 0, 0, 5'b10110, 1, 0, 5'b01100);
        add(0, 0, 0, 5'b10110, 1, 0, {3'b001, FE_BIT0, 1'b0});
`ifdef SERIAL_PATTERN_GENERATOR_PARITY_EN
        add(0, 0, 0, 5'b10110, 1, 0, 5'b01110);
`endif
        add(0, 0, 0, 5'b10110, 1, 0, DONE_O);
        add(0, 0, 0, 5'b10110, 1, 0, IDLE_O);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].st, tbl[i].ab, tbl[i].pat, tbl[i].rc, tbl[i].gp);
            step();
            check($sformatf("tbl%0d", i), tbl[i].e);
        end

        // three frames with gap 2: done lands at F*(PAT_W+P)+(F-1)*gap+1
        run_transfer(5'b11001, 2, 2, 0, dc);
        checks++;
        if (dc != 20 + 3 * P) begin
            errors++;
            $display("FAIL gap done cycle: got %0d required %0d", dc, 20 + 3 * P);
        end

        // abort in cycle 3; start with another pattern in cycle 2 must not disturb capture
        drive(0, 1, 0, 5'b10110, 0, 0); step(); check("abort c1", 5'b01100);
        drive(0, 0, 0, 5'b10110, 0, 0); step(); check("abort c2", 5'b00100);
        drive(0, 1, 0, 5'b01001, 3, 1); step(); check("abort c3", 5'b01100);
        drive(0, 0, 1, 5'b01001, 0, 0); step(); check("abort c4 done", DONE_O);
        drive(0, 0, 0, 5'b01001, 0, 0); step(); check("abort c5 ready", IDLE_O);
        step(); check("abort c6 stays idle", IDLE_O);

        // reset mid-transfer: no done pulse, then a clean transfer
        drive(0, 1, 0, 5'b10110, 2, 1); step(); check("rst c1", 5'b01100);
        drive(0, 0, 0, 5'b10110, 2, 1); step(); check("rst c2", 5'b00100);
        step(); check("rst c3", 5'b01100);
        drive(1, 0, 1, 5'b10110, 2, 1); step(); check("rst c4 idle", IDLE_O);
        drive(0, 0, 0, 5'b10110, 2, 1); step(); check("rst c5 no done", IDLE_O);
        run_transfer(5'b01101, 1, 1, 0, dc);

        // maximum frame count, then random transfers with occasional abort and noise
        run_transfer(PAT_W'($urandom), 4'd15, 3'd0, 0, dc);
        for (int t = 0; t < 40; t++) begin
            int idle_n;
            idle_n = $urandom_range(0, 2);
            for (int k = 0; k < idle_n; k++) begin
                drive(0, 0, 1'($urandom_range(0, 1)), PAT_W'($urandom), '0, '0);
                step();
                check("random idle", IDLE_O);
            end
            run_transfer(PAT_W'($urandom), CNT_W'($urandom_range(0, 3)),
                         GAP_W'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 7)),
                         (t % 2 == 0) ? 0 : 8, dc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_pattern_generator.md
SERIAL_PATTERN_GENERATOR -- requirements
Module: serial_pattern_generator

Interface
REQ-001 SHALL have parameter PAT_W, default 5: pattern length in bits.
REQ-002 SHALL have parameter CNT_W, default 4: width of repeat_cnt.
REQ-003 SHALL have parameter GAP_W, default 3: width of gap.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  request to transmit; sampled only while ready=1.
REQ-007 SHALL have port abort  in  1  terminate the transfer in progress.
REQ-008 SHALL have port pattern  in  PAT_W  frame bits, sent MSB first.
REQ-009 SHALL have port repeat_cnt  in  CNT_W  number of frames minus 1.
REQ-010 SHALL have port gap  in  GAP_W  idle cycles between frames.
REQ-011 SHALL have port ready  out  1  high iff state IDLE.
REQ-012 SHALL have port x  out  1  serial data bit; 0 whenever valid=0.
REQ-013 SHALL have port valid  out  1  x carries a frame bit this cycle.
REQ-014 SHALL have port frame_end  out  1  high on the last bit cycle of each frame.
REQ-015 SHALL have port done  out  1  one-cycle pulse when the transfer completes or is aborted.

Function
REQ-016 SHALL implement states IDLE, SEND, PAR, GAP, FIN; all outputs SHALL be decoded from registered state only (no input-to-output paths).
REQ-017 IDLE: on start=1, SHALL capture pattern, repeat_cnt and gap, load bit index PAT_W-1, and go to SEND; otherwise SHALL stay in IDLE.
REQ-018 Latency: start sampled at edge N SHALL make the first bit (pattern[PAT_W-1]) visible with valid=1 in the cycle after edge N.
REQ-019 SEND SHALL drive x=captured pattern[index] and valid=1; the index SHALL decrement once per cycle.
REQ-020 At index 0: the next state SHALL be PAR if parity is enabled; otherwise it SHALL be the frame-exit state per REQ-022.
REQ-021 PAR (one cycle) SHALL drive x = XOR of the captured pattern (even parity) with valid=1.
REQ-022 Frame exit: if frames remain and the captured gap is greater than 0, the next state SHALL be GAP; if frames remain and gap=0, it SHALL be SEND, reloading index PAT_W-1 back-to-back with no idle cycle; if no frames remain, it SHALL be FIN.
REQ-023 GAP SHALL last exactly the captured gap number of cycles with x=0 and valid=0, then go to SEND.
REQ-024 Frame count SHALL be repeat_cnt+1, with range 1..2^CNT_W; repeat_cnt=0 SHALL send exactly one frame.
REQ-025 FIN (one cycle) SHALL drive done=1, x=0 and valid=0, then go to IDLE; ready SHALL return 1 the cycle after done.
REQ-026 Total cycles from the first bit to done, exclusive, SHALL be F*(PAT_W+P)+(F-1)*gap, where F is the frame count and P is 1 with parity, else 0.
REQ-027 frame_end SHALL be 1 on the bit-0 cycle, or on the PAR cycle when parity is enabled.
REQ-028 abort=1 in SEND, PAR or GAP SHALL go to FIN at the next edge; the partial frame is dropped and done still pulses.
REQ-029 abort SHALL be ignored in IDLE and FIN; start SHALL be ignored outside IDLE, and captured values SHALL NOT change mid-transfer.
REQ-030 When start=1 and abort=1 in IDLE together, start SHALL win.

Reset
REQ-031 reset=1 at an edge SHALL force IDLE and clear the index, frame counter and gap counter, overriding start and abort.
REQ-032 Reset values SHALL be: ready=1, x=0, valid=0, frame_end=0, done=0.
REQ-033 Reset mid-transfer SHALL NOT produce a done pulse.

Configuration
REQ-034 With macro SERIAL_PATTERN_GENERATOR_PARITY_EN defined, the PAR state and the parity bit SHALL be compiled in, with P=1.
REQ-035 Without the macro, PAR SHALL be absent, P=0, and each frame SHALL be exactly PAT_W bits.

Verification
REQ-036 Reset; start, pattern=10110, repeat_cnt=0, gap=0 -> x=1,0,1,1,0 in cycles 1-5 with valid=1; frame_end in cycle 5; done in cycle 6; ready in cycle 7.
REQ-037 Same stimulus with PARITY_EN defined -> cycle 6 has x=1 (parity of three ones), valid=1 and frame_end=1; done in cycle 7.
REQ-038 pattern=10110, repeat_cnt=1, gap=0 -> contiguous 1011010110 in cycles 1-10; frame_end in cycles 5 and 10; done in cycle 11.
REQ-039 pattern=11001, repeat_cnt=2, gap=2 -> frames in cycles 1-5, 8-12 and 15-19; cycles 6-7 and 13-14 have valid=0 and x=0; done in cycle 20.
REQ-040 abort in cycle 3 of the first frame -> FIN in cycle 4 with done=1; ready=1 in cycle 5; a start asserted in cycle 2 with a different pattern is ignored.
REQ-041 reset asserted in cycle 3 -> cycle 4 has ready=1, x=0, valid=0 and done=0; a new start then transmits correctly.
